ldm_stm_sequencer: RTL and testbench

- Multi-cycle sequencer for ARM block data transfer instructions (LDM/STM).
- Sits between decode and the register file / memory interface.
- Walks a 16-bit register list lowest-index first. Drives the register file read index (STM) or write port (LDM), plus one word memory access per register.
- Optionally writes the updated base back through the register file write port.

---
 rtl/ldm_stm_sequencer_pkg.sv | 30 +++
 rtl/lowest_set_bit16.sv | 18 +
 rtl/ldm_stm_sequencer.sv | 151 +++++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and helpers for the LDM/STM block-transfer sequencer.
package ldm_stm_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StWb,
    StDone
  } state_e;

  localparam int unsigned WordBytes = 4;

  // Addressing mode as the {U,P} bit pair.
  typedef enum logic [1:0] {
    ModeDa = 2'b00,
    ModeDb = 2'b01,
    ModeIa = 2'b10,
    ModeIb = 2'b11
  } amode_e;

  function automatic logic [4:0] popcount16(input logic [15:0] vec);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + 5'(vec[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lowest_set_bit16.sv
// Combinational 16-to-4 priority encoder: index of the lowest set bit, with valid.
module lowest_set_bit16 (
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |vec_i;
    for (int i = 15; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list lowest-first, one memory word per register,
// with optional base writeback.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_BYTES = WordBytes
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [15:0]       reg_list_i,
  input  logic [3:0]        base_reg_i,
  input  logic [ADDR_W-1:0] base_val_i,
  input  logic              load_i,
  input  logic              up_i,
  input  logic              pre_i,
  input  logic              wback_i,
  input  logic [ADDR_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic              mem_req_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        reg_idx_o,
  output logic              reg_write_o,
  output logic [ADDR_W-1:0] reg_wdata_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] Step = ADDR_W'(WORD_BYTES);

  state_e            state_q, state_d;
  logic [15:0]       mask_q, mask_d, mask_nxt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] final_q, final_d;
  logic [3:0]        base_reg_q, base_reg_d;
  logic              load_q, load_d;
  logic              wb_en_q, wb_en_d;

  logic [4:0]        n_regs;
  logic [ADDR_W-1:0] span;
  logic [3:0]        lsb_idx;
  logic              lsb_valid;

  lowest_set_bit16 u_lsb (
    .vec_i   (mask_q),
    .idx_o   (lsb_idx),
    .valid_o (lsb_valid)
  );

  assign n_regs   = popcount16(reg_list_i);
  assign span     = ADDR_W'(n_regs) * Step;
  assign mask_nxt = mask_q & (mask_q - 16'd1);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    final_d     = final_q;
    base_reg_d  = base_reg_q;
    load_d      = load_q;
    wb_en_d     = wb_en_q;
    mem_req_o   = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    reg_idx_o   = '0;
    reg_write_o = 1'b0;
    reg_wdata_o = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mask_d     = reg_list_i;
          base_reg_d = base_reg_i;
          load_d     = load_i;
          // Loading the base register wins over writing it back.
          wb_en_d    = wback_i & ~(load_i & reg_list_i[base_reg_i]);
          final_d    = up_i ? base_val_i + span : base_val_i - span;
          unique case (amode_e'({up_i, pre_i}))
            ModeIa: addr_d = base_val_i;
            ModeIb: addr_d = base_val_i + Step;
            ModeDa: addr_d = base_val_i - span + Step;
            ModeDb: addr_d = base_val_i - span;
            default: addr_d = base_val_i;
          endcase
          state_d = (n_regs == 5'd0) ? StDone : StXfer;
        end
      end
      StXfer: begin
        busy_o      = 1'b1;
        mem_req_o   = lsb_valid;
        mem_write_o = ~load_q;
        mem_addr_o  = addr_q;
        reg_idx_o   = lsb_idx;
        if (load_q) begin
          reg_write_o = mem_ready_i;
          reg_wdata_o = mem_rdata_i;
        end
        if (mem_ready_i) begin
          mask_d = mask_nxt;
          addr_d = addr_q + Step;
          if (mask_nxt == 16'd0) begin
            state_d = wb_en_q ? StWb : StDone;
          end
        end
      end
      StWb: begin
        busy_o      = 1'b1;
        reg_idx_o   = base_reg_q;
        reg_write_o = 1'b1;
        reg_wdata_o = final_q;
        state_d     = StDone;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort takes effect in the reset cycle itself: no write or request escapes.
    if (rst_i) begin
      mem_req_o   = 1'b0;
      reg_write_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      base_reg_q <= '0;
      load_q     <= 1'b0;
      wb_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      final_q    <= final_d;
      base_reg_q <= base_reg_d;
      load_q     <= load_d;
      wb_en_q    <= wb_en_d;
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: directed plan cases plus random transfers against a list model.
module tb_ldm_stm_sequencer;

  localparam int unsigned AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [15:0]   reg_list_i;
  logic [3:0]    base_reg_i;
  logic [AW-1:0] base_val_i;
  logic          load_i;
  logic          up_i;
  logic          pre_i;
  logic          wback_i;
  logic [AW-1:0] mem_rdata_i;
  logic          mem_ready_i;
  logic          mem_req_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    reg_idx_o;
  logic          reg_write_o;
  logic [AW-1:0] reg_wdata_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  ldm_stm_sequencer #(
    .ADDR_W     (32),
    .WORD_BYTES (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .reg_list_i  (reg_list_i),
    .base_reg_i  (base_reg_i),
    .base_val_i  (base_val_i),
    .load_i      (load_i),
    .up_i        (up_i),
    .pre_i       (pre_i),
    .wback_i     (wback_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i),
    .mem_req_o   (mem_req_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .reg_idx_o   (reg_idx_o),
    .reg_write_o (reg_write_o),
    .reg_wdata_o (reg_wdata_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of run, required $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_req"}, AW'(mem_req_o), 0);
    chk({tag, " mem_write"}, AW'(mem_write_o), 0);
    chk({tag, " mem_addr"}, mem_addr_o, 0);
    chk({tag, " reg_idx"}, AW'(reg_idx_o), 0);
    chk({tag, " reg_write"}, AW'(reg_write_o), 0);
    chk({tag, " reg_wdata"}, reg_wdata_o, 0);
    chk({tag, " busy"}, AW'(busy_o), 0);
    chk({tag, " done"}, AW'(done_o), 0);
  endtask

  // Model: registers in ascending order at consecutive words starting from the lowest address.
  task automatic run_op(input logic [15:0] list, input logic [AW-1:0] base, input logic [3:0] rn,
                        input bit ld, input bit u, input bit p, input bit w, input int stall);
    logic [3:0]    regs[$];
    logic [AW-1:0] a0, fin, span, rd;
    int            n, s;
    bit            wb_exp;
    regs = {};
    for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(4'(i));
    n    = regs.size();
    span = AW'(n * 4);
    if (u) begin
      a0  = p ? base + 4 : base;
      fin = base + span;
    end else begin
      a0  = p ? base - span : base - span + 4;
      fin = base - span;
    end
    wb_exp = w && !(ld && list[rn]) && (n != 0);

    step();
    start_i = 1'b1; reg_list_i = list; base_val_i = base; base_reg_i = rn;
    load_i = ld; up_i = u; pre_i = p; wback_i = w;
    mem_ready_i = 1'($urandom_range(0, 1));
    step();
    // Everything below is scrambled: the sequencer must be working from latched copies.
    start_i = 1'($urandom_range(0, 1)); reg_list_i = 16'($urandom); base_val_i = $urandom;
    base_reg_i = 4'($urandom); load_i = 1'($urandom); up_i = 1'($urandom);
    pre_i = 1'($urandom); wback_i = 1'($urandom);

    for (int k = 0; k < n; k++) begin
      s = (stall < 0) ? $urandom_range(0, 2) : stall;
      for (int c = 0; c <= s; c++) begin
        mem_ready_i = (c == s);
        rd = $urandom;
        mem_rdata_i = rd;
        @(negedge clk_i);
        chk("xfer mem_req", AW'(mem_req_o), 1);
        chk("xfer mem_write", AW'(mem_write_o), AW'(!ld));
        chk("xfer mem_addr", mem_addr_o, a0 + AW'(4 * k));
        chk("xfer reg_idx", AW'(reg_idx_o), AW'(regs[k]));
        chk("xfer reg_write", AW'(reg_write_o), AW'(ld && (c == s)));
        if (ld && (c == s)) chk("xfer reg_wdata", reg_wdata_o, rd);
        chk("xfer busy", AW'(busy_o), 1);
        chk("xfer done", AW'(done_o), 0);
        step();
        start_i = 1'($urandom_range(0, 1));
        reg_list_i = 16'($urandom);
      end
    end

    mem_ready_i = 1'($urandom_range(0, 1));
    if (wb_exp) begin
      @(negedge clk_i);
      chk("wb mem_req", AW'(mem_req_o), 0);
      chk("wb reg_write", AW'(reg_write_o), 1);
      chk("wb reg_idx", AW'(reg_idx_o), AW'(rn));
      chk("wb reg_wdata", reg_wdata_o, fin);
      chk("wb busy", AW'(busy_o), 1);
      step();
    end

    start_i = 1'b1;
    reg_list_i = 16'hFFFF;
    @(negedge clk_i);
    chk("done pulse", AW'(done_o), 1);
    chk("done busy", AW'(busy_o), 0);
    chk("done mem_req", AW'(mem_req_o), 0);
    chk("done reg_write", AW'(reg_write_o), 0);
    step();
    start_i = 1'b0;
    @(negedge clk_i);
    chk("idle done", AW'(done_o), 0);
    chk("idle busy", AW'(busy_o), 0);
    chk("idle mem_req", AW'(mem_req_o), 0);
  endtask

  initial begin
    logic [15:0] rl;
    rst_i = 1'b1; start_i = 1'b0; reg_list_i = '0; base_reg_i = '0; base_val_i = '0;
    load_i = 1'b0; up_i = 1'b0; pre_i = 1'b0; wback_i = 1'b0;
    mem_rdata_i = '0; mem_ready_i = 1'b0;
    repeat (2) step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_all_zero("reset");

    // STM IA, writeback of base+16.
    run_op(16'h000F, 32'h0000_1000, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    // LDM DB, Rn=13.
    run_op(16'h8001, 32'h0000_2000, 4'd13, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    // LDM IA with three wait states per access.
    run_op(16'h0006, 32'h0000_3000, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 3);
    // Base register in the load list: writeback suppressed.
    run_op(16'h0004, 32'h0000_4000, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    // Empty list.
    run_op(16'h0000, 32'h0000_5000, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    // Full list, DB, wrapping below zero.
    run_op(16'hFFFF, 32'h0000_0010, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    // DA, IB wrap above 2^32.
    run_op(16'h0A50, 32'h0000_0100, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    run_op(16'h8421, 32'hFFFF_FFF8, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, -1);

    // Reset in the second transfer of a 4-register STM.
    step();
    start_i = 1'b1; reg_list_i = 16'h00F0; base_val_i = 32'h0000_5000; base_reg_i = 4'd1;
    load_i = 1'b0; up_i = 1'b1; pre_i = 1'b0; wback_i = 1'b1; mem_ready_i = 1'b1;
    step();
    start_i = 1'b0;
    @(negedge clk_i);
    chk("rst pre addr", mem_addr_o, 32'h0000_5000);
    chk("rst pre idx", AW'(reg_idx_o), 4);
    step();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst cycle mem_req", AW'(mem_req_o), 0);
    chk("rst cycle reg_write", AW'(reg_write_o), 0);
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk_all_zero("after rst");
    step();
    @(negedge clk_i);
    chk_all_zero("after rst idle");
    run_op(16'h0300, 32'h0000_6000, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, -1);

    for (int t = 0; t < 40; t++) begin
      rl = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      run_op(rl, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
